bram_port_responder: RTL
========================

Name: bram_port_responder

Overview:
- BRAM-side responder for the 13-bit address / 32-bit data trig/done word-access buses driven by the row read and row write controllers.
- Arbitrates one read bus and one write bus onto a single synchronous BRAM port: 8192 x 32 words, holding a 512x512-bit image.
- Performs each access and returns data and done with a four-phase handshake.
- Sits in the top level between the filter datapath (row load, row write-back) and the image BRAM primitive.

Parameters:
- ADDR_W, 13, word address width.
- DATA_W, 32, word data width.
- RD_LATENCY, 1, BRAM read latency in cycles from the enable edge to valid dout; legal values 1..3.
- WR_FIRST, 1, tie-break winner after reset: 1 means write, 0 means read.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_rd_addr  in  ADDR_W  read word address; stable while i_rd_trig is high.
- i_rd_trig  in  1  read request level.
- o_rd_data  out  DATA_W  read word; valid while o_rd_done is high, held until the next read completes.
- o_rd_done  out  1  read acknowledge.
- i_wr_addr  in  ADDR_W  write word address; stable while i_wr_trig is high.
- i_wr_data  in  DATA_W  write word; stable while i_wr_trig is high.
- i_wr_trig  in  1  write request level.
- o_wr_done  out  1  write acknowledge.
- o_bram_en  out  1  BRAM port enable.
- o_bram_we  out  1  BRAM write enable.
- o_bram_addr  out  ADDR_W  BRAM address.
- o_bram_din  out  DATA_W  BRAM write data.
- i_bram_dout  in  DATA_W  BRAM read data.
- o_busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs are 0, state is IDLE, last_grant = (WR_FIRST ? read : write), so the first tie goes to the WR_FIRST side.
- All outputs are registered.
- States: IDLE, RD_ISSUE, RD_WAIT, RD_ACK, WR_ISSUE, WR_ACK.

IDLE:
- Samples both trigs each edge.
- Only one trig high: grant that side.
- Both high: grant the side opposite last_grant, then update last_grant.
- Read grant: o_bram_en=1, o_bram_we=0, o_bram_addr=i_rd_addr; go to RD_ISSUE.
- Write grant: o_bram_en=1, o_bram_we=1, o_bram_addr=i_wr_addr, o_bram_din=i_wr_data; go to WR_ISSUE.

RD_ISSUE:
- o_bram_en is high for exactly this one cycle.
- Next edge: en=0; latency counter loads RD_LATENCY-1; go to RD_WAIT. For RD_LATENCY=1 the counter is already 0.

RD_WAIT:
- Counter nonzero: decrement.
- Counter zero: o_rd_data<=i_bram_dout, o_rd_done<=1, go to RD_ACK.

WR_ISSUE:
- en and we are high for exactly one cycle.
- Next edge: en=0, we=0, o_wr_done<=1, go to WR_ACK.

RD_ACK / WR_ACK:
- Hold done high while the matching trig is sampled high.
- On the first edge the trig is sampled low: done<=0, go to IDLE.

Timing (E0 = edge at which the trig is sampled high in IDLE):
- Read: o_rd_done rises at edge E0+RD_LATENCY+1.
- Write: o_wr_done rises at edge E0+1; BRAM commits at E0+1.
- A requester must see its trig sampled low at least once between accesses. Minimum back-to-back period for the same requester is RD_LATENCY+3 cycles (read) or 3 cycles (write).

Boundary conditions:
- Trig held high after done: no second access; done stays high indefinitely.
- Trig dropped before done (protocol violation): the access still completes, done pulses for one cycle, then the block returns to IDLE.
- Competing request while busy: waits in IDLE sampling; it is never dropped, and the address is sampled only at grant.
- Address 8191: no wrap logic; the address is passed verbatim.
- Read-after-write to the same address by different requesters is strictly ordered by grant order.
- Reset mid-operation: outputs clear asynchronously and the access is abandoned. A write is committed only if the E0+1 edge occurred before reset. Requesters must re-issue after reset.
- o_rd_data is not cleared by a new request; it changes only on read capture.

Decomposition:
- Shared include file bram_if_defs.vh holds BRAM_ADDR_W=13, BRAM_DATA_W=32, and the state localparams used for debug probes.
- One natural sub-module: rr_arbiter_2. It is combinational grant logic plus the last_grant register, with inputs req[1:0] and accept, and output gnt[1:0].

Test Plan:
1. Reset with random input levels -> all outputs 0, o_busy=0; first release cycle with idle trigs -> o_bram_en stays 0.
2. Write addr 0x1ABC, data 0xDEADBEEF -> en=we=1 for exactly one cycle with addr 0x1ABC and din 0xDEADBEEF; o_wr_done rises at E0+1 and holds until trig drops, then falls one edge later.
3. Read 0x1ABC against a BRAM model, RD_LATENCY=2 -> en=1 for one cycle with we=0; o_rd_done at E0+3 with o_rd_data=0xDEADBEEF. Repeat at addresses 0 and 8191 with distinct patterns.
4. Both trigs raised in the same cycle right after reset, WR_FIRST=1 -> write served first and read served after the write ACK completes. Next simultaneous pair -> read served first.
5. Read trig held high 20 cycles past done -> exactly one en pulse; o_rd_done stays 1 for all 20 cycles.
6. i_rstn asserted during RD_WAIT -> all outputs 0 immediately. After release, a fresh read of 0x0005 returns the model value with nominal latency.

Source files
------------

// File: rtl/bram_port_responder_pkg.sv
// Shared definitions for the BRAM port responder: bus widths, FSM states,
// grant encodings and latency counter sizing.
package bram_port_responder_pkg;

    // 8192 x 32-bit words hold one 512x512-bit image.
    localparam int BRAM_ADDR_W = 13;
    localparam int BRAM_DATA_W = 32;

    // Wide enough to count RD_LATENCY-1 for latencies 1..3.
    localparam int LAT_CNT_W = 2;

    // Bit positions inside the two-entry request/grant vectors.
    localparam int REQ_RD = 0;
    localparam int REQ_WR = 1;

    // Encoding of the side that won the most recent tie.
    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_RD_ACK   = 3'd3,
        ST_WR_ISSUE = 3'd4,
        ST_WR_ACK   = 3'd5
    } state_e;

endpackage

// File: rtl/bram_port_responder_if.sv
// Bus bundle between the row read/write controllers, the responder and the
// image BRAM. The slave modport is the responder's view; the master modport
// is the view of everything around it (requesters plus BRAM).
interface bram_port_responder_if;
    import bram_port_responder_pkg::*;

    // Row read controller side
    logic [BRAM_ADDR_W-1:0] rd_addr;
    logic                   rd_trig;
    logic [BRAM_DATA_W-1:0] rd_data;
    logic                   rd_done;

    // Row write controller side
    logic [BRAM_ADDR_W-1:0] wr_addr;
    logic [BRAM_DATA_W-1:0] wr_data;
    logic                   wr_trig;
    logic                   wr_done;

    // BRAM primitive side
    logic                   bram_en;
    logic                   bram_we;
    logic [BRAM_ADDR_W-1:0] bram_addr;
    logic [BRAM_DATA_W-1:0] bram_din;
    logic [BRAM_DATA_W-1:0] bram_dout;

    // Status
    logic                   busy;

    modport slave (
        input  rd_addr, rd_trig, wr_addr, wr_data, wr_trig, bram_dout,
        output rd_data, rd_done, wr_done, bram_en, bram_we, bram_addr, bram_din, busy
    );

    modport master (
        output rd_addr, rd_trig, wr_addr, wr_data, wr_trig, bram_dout,
        input  rd_data, rd_done, wr_done, bram_en, bram_we, bram_addr, bram_din, busy
    );

endinterface

// File: rtl/bram_port_responder_rr_arbiter_2.sv
// Two-way round-robin arbiter. A lone request wins outright; on a tie the
// side that did not win the previous tie is granted. Only ties move the
// last_grant pointer, so an uncontested access never skews fairness.
module rr_arbiter_2
    import bram_port_responder_pkg::*;
#(
    parameter int WR_FIRST = 1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant decode and tie-pointer update, taken only when the grant is accepted.
    always_comb begin
        o_gnt        = 2'b00;
        last_grant_d = last_grant_q;
        unique case (i_req)
            2'b01: o_gnt = 2'b01;
            2'b10: o_gnt = 2'b10;
            2'b11: begin
                if (last_grant_q == GRANT_WR) begin
                    o_gnt = 2'b01;
                    if (i_accept) last_grant_d = GRANT_RD;
                end else begin
                    o_gnt = 2'b10;
                    if (i_accept) last_grant_d = GRANT_WR;
                end
            end
            default: o_gnt = 2'b00;
        endcase
    end

    // Tie pointer starts on the opposite side so the first tie favours WR_FIRST.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_grant_q <= (WR_FIRST != 0) ? GRANT_RD : GRANT_WR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/bram_port_responder.sv
// BRAM-side responder: serialises the row read and row write trig/done buses
// onto one synchronous BRAM port and acknowledges each access with a
// four-phase handshake. Every output comes straight from a flop.
module bram_port_responder
    import bram_port_responder_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int WR_FIRST   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    bram_port_responder_if.slave  bus
);

    state_e                 state_q,     state_d;
    logic                   bram_en_q,   bram_en_d;
    logic                   bram_we_q,   bram_we_d;
    logic [BRAM_ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [BRAM_DATA_W-1:0] bram_din_q,  bram_din_d;
    logic [BRAM_DATA_W-1:0] rd_data_q,   rd_data_d;
    logic                   rd_done_q,   rd_done_d;
    logic                   wr_done_q,   wr_done_d;
    logic                   busy_q,      busy_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q,   lat_cnt_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;

    assign req[REQ_RD] = bus.rd_trig;
    assign req[REQ_WR] = bus.wr_trig;
    assign accept      = (state_q == ST_IDLE);

    rr_arbiter_2 #(
        .WR_FIRST (WR_FIRST)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_req    (req),
        .i_accept (accept),
        .o_gnt    (gnt)
    );

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        bram_en_d   = bram_en_q;
        bram_we_d   = bram_we_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        rd_data_d   = rd_data_q;
        rd_done_d   = rd_done_q;
        wr_done_d   = wr_done_q;
        lat_cnt_d   = lat_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt[REQ_WR]) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b1;
                    bram_addr_d = bus.wr_addr;
                    bram_din_d  = bus.wr_data;
                    state_d     = ST_WR_ISSUE;
                end else if (gnt[REQ_RD]) begin
                    bram_en_d   = 1'b1;
                    bram_we_d   = 1'b0;
                    bram_addr_d = bus.rd_addr;
                    state_d     = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                bram_en_d = 1'b0;
                lat_cnt_d = LAT_CNT_W'(RD_LATENCY - 1);
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                end else begin
                    rd_data_d = bus.bram_dout;
                    rd_done_d = 1'b1;
                    state_d   = ST_RD_ACK;
                end
            end
            ST_RD_ACK: begin
                if (!bus.rd_trig) begin
                    rd_done_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_ISSUE: begin
                bram_en_d = 1'b0;
                bram_we_d = 1'b0;
                wr_done_d = 1'b1;
                state_d   = ST_WR_ACK;
            end
            ST_WR_ACK: begin
                if (!bus.wr_trig) begin
                    wr_done_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                bram_en_d = 1'b0;
                bram_we_d = 1'b0;
                rd_done_d = 1'b0;
                wr_done_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            rd_data_q   <= '0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            busy_q      <= 1'b0;
            lat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            rd_data_q   <= rd_data_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
            busy_q      <= busy_d;
            lat_cnt_q   <= lat_cnt_d;
        end
    end

    assign bus.bram_en   = bram_en_q;
    assign bus.bram_we   = bram_we_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = bram_din_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.busy      = busy_q;

endmodule
